// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and baud-rate constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int CLK_FREQ_HZ = 100_000_000;
    localparam int BAUD        = 9600;

    // Rounded to nearest: 100 MHz / 9600 = 10416.67 -> 10417.
    // The transmitter uses this same default so both ends agree on bit time.
    localparam int CLKS_PER_BIT_DEFAULT = (CLK_FREQ_HZ + BAUD / 2) / BAUD;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_byte_if.sv
// Received-byte bus from the UART receiver to the byte-to-letter mapper.
// Latency: n/a (wires only); rx_valid and frame_err are single-cycle strobes.
// Backpressure: none; the consumer must take the byte on its strobe or read rx_data later.
// Ports: rx_data (8, last good byte), rx_valid (strobe), frame_err (strobe), busy (level).
interface uart_rx_byte_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    modport master (output rx_data, output rx_valid, output frame_err, output busy);
    modport slave  (input  rx_data, input  rx_valid, input  frame_err, input  busy);

endinterface

// File: rtl/uart_rx_byte_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous pins (UART rx, buttons, ...).
// Latency: 2 clk from pin to q.
// Backpressure: none.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronised out).
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, LSB first, mid-bit sampling, stop-bit checking.
// Latency: strobe 3+HALF_BIT+9*CLKS_PER_BIT clk after rx is first sampled low.
// Backpressure: none; rx_data holds the last good byte until the next good frame.
// Ports: clk, rst (sync, active-high), rx (async pin, idle high),
//        rx_if.master {rx_data, rx_valid, frame_err, busy}.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT   // must be >= 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    uart_rx_byte_if.master  rx_if
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_s;

    rx_state_e        state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic [7:0]       data_q,    data_d;
    logic             valid_q,   valid_d;
    logic             ferr_q,    ferr_d;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                // Re-check the line half a bit in; a short low pulse is a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) state_d   = STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK_WAIT;
                    end
                end
            end
            BREAK_WAIT: begin
                // A line held low (break) must go high before a new start edge counts.
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rx_if.rx_data   = data_q;
    assign rx_if.rx_valid  = valid_q;
    assign rx_if.frame_err = ferr_q;
    assign rx_if.busy      = (state_q != IDLE);

endmodule
